mult_control: RTL and testbench
===============================

Name: mult_control

Overview:
Sequencer for the 8-bit shift-add multiplier datapath. It drives the Load/Shift_En/Reset-style controls of the A and B shift registers and the add/subtract latch of the 9-bit adder (X:A).
- Iterations 0..N_BITS-2: add S when M=1.
- Final iteration: subtract S when M=1 (two's-complement multiplicand).
- Every iteration ends with one arithmetic right shift of X:A:B.

Parameters:
N_BITS, 8, number of multiplier bits / iterations; counter width is $clog2(N_BITS).

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high; returns FSM to IDLE
Run  input  1  start request, level, already debounced and synchronized
ClearA_LoadB  input  1  user request: clear A/X and load B from switches
M  input  1  current LSB of multiplier register B (B shift-out bit)
Clr_Ld  output  1  clear A and X, load B; datapath acts on next edge
ClearA  output  1  clear A and X only (start of run)
Add  output  1  latch X:A <= sext(A)+sext(S)
Sub  output  1  latch X:A <= sext(A)-sext(S)
Shift_En  output  1  shift X->A->B right by one
Done  output  1  product valid in A:B

Behaviour:
- One clock; reset is synchronous and active-high, ports named Clk and Reset.
- States: IDLE, START, ARITH, SHIFT, HOLD. Iteration counter `cnt` is 0..N_BITS-1.
- Reset at any edge, including mid-run, forces the following:
  - state=IDLE and cnt=0;
  - after that edge, ClearA, Add, Sub, Shift_En and Done are 0;
  - Clr_Ld follows the IDLE rule below.
- IDLE:
  - Done=0; all other outputs 0 except Clr_Ld = ClearA_LoadB.
  - Run=1 -> START. Run has priority: if Run and ClearA_LoadB are both 1, Clr_Ld=0 that cycle.
- START: ClearA=1 for exactly one cycle; cnt<=0; -> ARITH.
- ARITH:
  - if cnt<N_BITS-1: Add=M, Sub=0;
  - if cnt==N_BITS-1: Add=0, Sub=M;
  - Add and Sub are never both 1; -> SHIFT.
- SHIFT:
  - Shift_En=1.
  - cnt==N_BITS-1 -> HOLD.
  - otherwise cnt<=cnt+1 -> ARITH.
- HOLD:
  - Done=1; all other outputs 0; ClearA_LoadB ignored.
  - Run=0 -> IDLE. Run held high stays in HOLD, so there is no auto-restart.
- Run and ClearA_LoadB are ignored in START/ARITH/SHIFT; a Run drop mid-run does not abort.
- Output timing:
  - Outputs are Moore from the state register, except Add/Sub (state & M) and Clr_Ld (IDLE & input).
  - The datapath registers act on the edge ending the cycle in which a control is high.
- Latency:
  - The Run-sampling edge enters START (cycle 0).
  - Iteration i has ARITH at cycle 1+2i and SHIFT at cycle 2+2i.
  - Last SHIFT is at cycle 2*N_BITS (16); Done is first high at cycle 2*N_BITS+1 (17).
- M is sampled combinationally during ARITH; B has not yet shifted for that iteration.
- The counter never wraps during a run; it is cleared in START and on reset.
- Exactly one of {ClearA, Add, Sub, Shift_En, Clr_Ld} is high in any cycle, or none.

Decomposition:
- Package mult_pkg:
  - typedef enum logic [2:0] state_t {IDLE, START, ARITH, SHIFT, HOLD};
  - localparam MULT_BITS = 8.
- Sub-module mult_iter_counter:
  - synchronous clear, increment enable, terminal-count flag last = (cnt==N_BITS-1).
  - The FSM uses `last` for the ARITH Add/Sub select and the SHIFT exit.

Test Plan:
1. Reset=1 for 2 cycles while in ARITH (cycle 5 of a run). Required next cycle: state IDLE, ClearA/Add/Sub/Shift_En/Done all 0, and a fresh Run=1 starts at cycle 0.
2. B=0x07 (M sequence 1,1,1,0,0,0,0,0), Run pulse held high.
   - Add=1 at cycles 1,3,5 and 0 at 7,9,11,13; Sub=0 at 15.
   - Shift_En=1 at cycles 2,4,...,16; Done=1 at 17 and stays while Run=1.
3. Full bench with reg_8 models: S=0xFD (-3), B=0x05. Required: A:B=0xFFF1 (-15) at Done. With B=0x81 (-127), S=0x02, required A:B=0xFF02 (-254), with Sub=1 at cycle 15.
4. In IDLE, ClearA_LoadB=1 with Run=0 -> Clr_Ld=1 same cycle. With Run=1 in the same cycle -> Clr_Ld=0 and START next.
5. In HOLD, hold Run=1 for 10 cycles -> Done stays 1, no control pulses. Drop Run -> IDLE next edge, Done=0. Re-raise Run -> ClearA pulses exactly once.
6. Drop Run at cycle 8 mid-run -> sequence completes unchanged and Done rises at 17, then IDLE on the next edge (Run already 0).

Source files
------------

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state encoding and width for the shift-add multiplier sequencer
package mult_pkg;
  localparam int MULT_BITS = 8;

  typedef enum logic [2:0] {IDLE, START, ARITH, SHIFT, HOLD} state_t;
endpackage

// File: rtl/mult_iter_counter.sv
// rtl/mult_iter_counter.sv - iteration counter with terminal-count flag for the multiplier sequencer
module mult_iter_counter
  import mult_pkg::*;
#(
  parameter int N_BITS = MULT_BITS,
  localparam int CW = (N_BITS > 1) ? $clog2(N_BITS) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic last
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CW'(N_BITS - 1));

endmodule

// File: rtl/mult_control.sv
// rtl/mult_control.sv - sequencer for the 8-bit shift-add multiplier datapath
module mult_control
  import mult_pkg::*;
#(
  parameter int N_BITS = MULT_BITS
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Clr_Ld,
  output logic ClearA,
  output logic Add,
  output logic Sub,
  output logic Shift_En,
  output logic Done
);

  state_t state_q, state_d;
  logic   cnt_clr;
  logic   cnt_inc;
  logic   last;

  mult_iter_counter #(.N_BITS(N_BITS)) u_iter_counter (
    .clk  (Clk),
    .reset(Reset),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .last (last)
  );

  always_comb begin
    state_d  = state_q;
    Clr_Ld   = 1'b0;
    ClearA   = 1'b0;
    Add      = 1'b0;
    Sub      = 1'b0;
    Shift_En = 1'b0;
    Done     = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        // Run wins over a simultaneous load request
        Clr_Ld = ClearA_LoadB & ~Run;
        if (Run) state_d = START;
      end
      START: begin
        ClearA  = 1'b1;
        cnt_clr = 1'b1;
        state_d = ARITH;
      end
      ARITH: begin
        // final multiplier bit carries negative weight in two's complement
        Add     = M & ~last;
        Sub     = M & last;
        state_d = SHIFT;
      end
      SHIFT: begin
        Shift_En = 1'b1;
        if (last) begin
          state_d = HOLD;
        end else begin
          cnt_inc = 1'b1;
          state_d = ARITH;
        end
      end
      HOLD: begin
        Done = 1'b1;
        if (!Run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_mult_control.sv
// tb/tb_mult_control.sv - self-checking bench for mult_control driving a behavioural X:A:B datapath
module tb_mult_control;

  logic Clk = 1'b0;
  logic Reset, Run, ClearA_LoadB, M;
  logic Clr_Ld, ClearA, Add, Sub, Shift_En, Done;

  logic [7:0] sw, s_reg, a_q, b_q;
  logic       x_q;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  s;
    logic [7:0]  b;
    logic [15:0] prod;
    int          drop;
    bit          clr_with_run;
  } vec_t;

  vec_t vecs[6];

  mult_control dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Run         (Run),
    .ClearA_LoadB(ClearA_LoadB),
    .M           (M),
    .Clr_Ld      (Clr_Ld),
    .ClearA      (ClearA),
    .Add         (Add),
    .Sub         (Sub),
    .Shift_En    (Shift_En),
    .Done        (Done)
  );

  always #5 Clk = ~Clk;

  assign M = b_q[0];

  always @(posedge Clk) begin
    if (Reset) begin
      a_q <= '0;
      b_q <= '0;
      x_q <= 1'b0;
    end else if (Clr_Ld) begin
      a_q <= '0;
      x_q <= 1'b0;
      b_q <= sw;
    end else if (ClearA) begin
      a_q <= '0;
      x_q <= 1'b0;
    end else if (Add) begin
      {x_q, a_q} <= {a_q[7], a_q} + {s_reg[7], s_reg};
    end else if (Sub) begin
      {x_q, a_q} <= {a_q[7], a_q} - {s_reg[7], s_reg};
    end else if (Shift_En) begin
      a_q <= {x_q, a_q[7:1]};
      b_q <= {a_q[0], b_q[7:1]};
    end
  end

  function automatic logic [5:0] ctl();
    return {Clr_Ld, ClearA, Add, Sub, Shift_En, Done};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [5:0] exp;
    @(negedge Clk);
    sw = v.b;
    s_reg = v.s;
    ClearA_LoadB = 1'b1;
    Run = 1'b0;
    #1 check($sformatf("v%0d clr_ld_idle", idx), 16'(Clr_Ld), 16'd1);
    @(negedge Clk);
    ClearA_LoadB = v.clr_with_run;
    Run = 1'b1;
    #1 check($sformatf("v%0d clr_ld_prio", idx), 16'(Clr_Ld), 16'd0);
    for (int c = 0; c <= 30; c++) begin
      @(negedge Clk);
      exp = '0;
      exp[4] = (c == 0);
      if ((c % 2 == 1) && (c <= 13)) exp[3] = v.b[(c - 1) / 2];
      exp[2] = (c == 15) && v.b[7];
      exp[1] = (c % 2 == 0) && (c >= 2) && (c <= 16);
      exp[0] = (c == 17) || ((c > 17) && (c <= v.drop));
      check($sformatf("v%0d ctl c%0d", idx, c), 16'(ctl()), 16'(exp));
      if (c == 17) check($sformatf("v%0d product", idx), {a_q, b_q}, v.prod);
      ClearA_LoadB = 1'b0;
      Run = (c < v.drop);
    end
  endtask

  initial begin
    vecs[0] = '{s: 8'h03, b: 8'h07, prod: 16'h0015, drop: 28, clr_with_run: 1'b0};
    vecs[1] = '{s: 8'hFD, b: 8'h05, prod: 16'hFFF1, drop: 20, clr_with_run: 1'b0};
    vecs[2] = '{s: 8'h02, b: 8'h81, prod: 16'hFF02, drop: 18, clr_with_run: 1'b1};
    vecs[3] = '{s: 8'h7F, b: 8'h7F, prod: 16'h3F01, drop: 8,  clr_with_run: 1'b0};
    vecs[4] = '{s: 8'h80, b: 8'h80, prod: 16'h4000, drop: 1,  clr_with_run: 1'b1};
    vecs[5] = '{s: 8'hFF, b: 8'hFF, prod: 16'h0001, drop: 17, clr_with_run: 1'b0};

    Reset = 1'b1;
    Run = 1'b0;
    ClearA_LoadB = 1'b0;
    sw = '0;
    s_reg = '0;
    repeat (2) @(negedge Clk);
    check("reset ctl", 16'(ctl()), 16'd0);
    Reset = 1'b0;

    // Reset asserted mid-run while the sequencer sits in ARITH
    @(negedge Clk);
    sw = 8'h07;
    s_reg = 8'h03;
    ClearA_LoadB = 1'b1;
    @(negedge Clk);
    ClearA_LoadB = 1'b0;
    Run = 1'b1;
    for (int c = 0; c <= 5; c++) @(negedge Clk);
    check("arith c5 before reset", 16'(ctl()), 16'b001000);
    Reset = 1'b1;
    Run = 1'b0;
    @(negedge Clk);
    check("reset held ctl", 16'(ctl()), 16'd0);
    @(negedge Clk);
    check("reset second ctl", 16'(ctl()), 16'd0);
    Reset = 1'b0;
    @(negedge Clk);
    check("after reset idle ctl", 16'(ctl()), 16'd0);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
